// File: rtl/usr_param_if.sv
`default_nettype none
// ============================================================================
// Module   : usr_param_if
// Brief    : Control, data and status bundle for the usr_param shift register.
// Revision : 1.0
// ============================================================================
interface usr_param_if #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH + 1)
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic             sinl;
    logic             sinr;
    logic             start;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, din, sinl, sinr, start, amt,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, mode, din, sinl, sinr, start, amt,
        output q, sout_l, sout_r, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/usr_param.sv
`default_nettype none
// ============================================================================
// Module   : usr_param
// Brief    : Universal shift register with single-step ops and stallable
//            multi-step shift/rotate runs.
// Revision : 1.0
// ============================================================================
module usr_param #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH + 1)
) (
    input  wire logic    clk,
    input  wire logic    reset,
    usr_param_if.slave   bus
);

    localparam logic [2:0]    C_OP_HOLD  = 3'b000;
    localparam logic [2:0]    C_OP_SHL   = 3'b001;
    localparam logic [2:0]    C_OP_SHR   = 3'b010;
    localparam logic [2:0]    C_OP_LOAD  = 3'b011;
    localparam logic [2:0]    C_OP_ROTL  = 3'b100;
    localparam logic [2:0]    C_OP_ROTR  = 3'b101;
    localparam logic [2:0]    C_OP_ASR   = 3'b110;
    localparam logic [2:0]    C_OP_CLEAR = 3'b111;
    localparam logic [AW-1:0] C_MAX_AMT  = AW'(WIDTH);
    localparam logic [AW-1:0] C_ONE      = AW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q,   cnt_d;
    logic [2:0]       op_q,    op_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [AW-1:0]    w_amt_clamped;
    logic             w_is_multi;

    function automatic logic [WIDTH-1:0] f_step(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] load,
        input logic             sl,
        input logic             sr
    );
        case (op)
            C_OP_SHL:   f_step = {cur[WIDTH-2:0], sl};
            C_OP_SHR:   f_step = {sr, cur[WIDTH-1:1]};
            C_OP_LOAD:  f_step = load;
            C_OP_ROTL:  f_step = {cur[WIDTH-2:0], cur[WIDTH-1]};
            C_OP_ROTR:  f_step = {cur[0], cur[WIDTH-1:1]};
            C_OP_ASR:   f_step = {cur[WIDTH-1], cur[WIDTH-1:1]};
            C_OP_CLEAR: f_step = '0;
            default:    f_step = cur;
        endcase
    endfunction

    assign w_amt_clamped = (bus.amt > C_MAX_AMT) ? C_MAX_AMT : bus.amt;
    assign w_is_multi    = (bus.mode == C_OP_SHL)  || (bus.mode == C_OP_SHR) ||
                           (bus.mode == C_OP_ROTL) || (bus.mode == C_OP_ROTR) ||
                           (bus.mode == C_OP_ASR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_is_multi) begin
                        // Latch the op; a zero-length run completes without entering RUN.
                        op_d  = bus.mode;
                        cnt_d = w_amt_clamped;
                        if (w_amt_clamped != '0) begin
                            state_d = ST_RUN;
                            busy_d  = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                        end
                    end else begin
                        q_d    = f_step(bus.mode, q_q, bus.din, bus.sinl, bus.sinr);
                        done_d = 1'b1;
                    end
                end else if (bus.en) begin
                    q_d = f_step(bus.mode, q_q, bus.din, bus.sinl, bus.sinr);
                end
            end
            ST_RUN: begin
                if (bus.en) begin
                    q_d   = f_step(op_q, q_q, bus.din, bus.sinl, bus.sinr);
                    cnt_d = cnt_q - C_ONE;
                    if (cnt_q == C_ONE) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= C_OP_HOLD;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.q      = q_q;
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.sout_r = q_q[0];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_usr_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_usr_param
// Brief    : Randomised scoreboard bench for usr_param (WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_usr_param;
    localparam int W  = 8;
    localparam int AW = $clog2(W + 1);

    logic clk   = 1'b0;
    logic reset = 1'b0;

    usr_param_if #(.WIDTH(W), .AW(AW)) bus();
    usr_param    #(.WIDTH(W), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mq;          // reference register contents
    logic [W-1:0] exp_q[$];    // expected q at each done pulse
    int           exp_b[$];    // expected busy-high cycles before that pulse

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Result of n steps of op from q0, with sl[k]/sr[k] the serial bits at step k.
    function automatic logic [W-1:0] ref_multi(input logic [2:0] op, input logic [W-1:0] q0,
                                               input logic [W-1:0] d, input int n,
                                               input logic [15:0] sl, input logic [15:0] sr);
        logic [2*W-1:0]      acc;
        logic signed [W-1:0] s;
        int                  r;
        r = n % W;
        case (op)
            3'b001: begin
                acc = {{W{1'b0}}, q0} << n;
                for (int k = 0; k < n; k++) if (sl[k]) acc[n-1-k] = 1'b1;
                return acc[W-1:0];
            end
            3'b010: begin
                acc = {{W{1'b0}}, q0} >> n;
                for (int k = 0; k < n; k++) if (sr[k]) acc[W-n+k] = 1'b1;
                return acc[W-1:0];
            end
            3'b011: return d;
            3'b100: return (q0 << r) | (q0 >> (W - r));
            3'b101: return (q0 >> r) | (q0 << (W - r));
            3'b110: begin s = q0; return s >>> n; end
            3'b111: return '0;
            default: return q0;
        endcase
    endfunction

    // Monitor: pops an expectation at every done pulse.
    int bcnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            bcnt = 0;
        end else begin
            check("busy_done_exclusive", {31'b0, bus.busy & bus.done}, 32'd0);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 q=%0h", bus.q);
                end else begin
                    check("done_q", {24'b0, bus.q}, {24'b0, exp_q.pop_front()});
                    check("busy_len", bcnt, exp_b.pop_front());
                end
                bcnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input logic [2:0] mode, input logic [W-1:0] din,
                             input logic sl, input logic sr, input logic en);
        bus.start = 1'b0; bus.en = en; bus.mode = mode; bus.din = din;
        bus.sinl = sl; bus.sinr = sr; bus.amt = AW'($urandom);
        tick();
        if (en) mq = ref_multi(mode, mq, din, 1, {15'b0, sl}, {15'b0, sr});
        check("idle_q", {24'b0, bus.q}, {24'b0, mq});
        check("sout_l", {31'b0, bus.sout_l}, {31'b0, mq[W-1]});
        check("sout_r", {31'b0, bus.sout_r}, {31'b0, mq[0]});
        check("idle_busy", {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic start_single(input logic [2:0] mode, input logic [W-1:0] din);
        bus.start = 1'b1; bus.mode = mode; bus.din = din; bus.en = 1'($urandom);
        bus.amt = AW'($urandom);
        tick();
        mq = ref_multi(mode, mq, din, 1, 16'b0, 16'b0);
        exp_q.push_back(mq);
        exp_b.push_back(0);
        check("single_q", {24'b0, bus.q}, {24'b0, mq});
        check("single_busy", {31'b0, bus.busy}, 32'd0);
        bus.start = 1'b0;
    endtask

    // Preload q0, start op with amt, random stalls; two forced stalls at step stall_at.
    task automatic run_multi(input logic [2:0] op, input logic [W-1:0] q0, input logic [AW-1:0] amt,
                             input int stall_pct, input int stall_at, input bit poke);
        int n, steps, cycles, stall_left;
        logic [15:0] sl, sr;
        logic [W-1:0] qs, e;
        logic en;
        start_single(3'b011, q0);
        qs = mq;
        bus.start = 1'b1; bus.mode = op; bus.amt = amt;
        bus.en = 1'($urandom); bus.din = W'($urandom);
        tick();
        n = (int'(amt) > W) ? W : int'(amt);
        check("e0_q", {24'b0, bus.q}, {24'b0, qs});
        if (n == 0) begin
            exp_q.push_back(mq);
            exp_b.push_back(0);
            check("e0_busy_zero", {31'b0, bus.busy}, 32'd0);
            bus.start = 1'b0;
            return;
        end
        check("e0_busy", {31'b0, bus.busy}, 32'd1);
        steps = 0; cycles = 0; stall_left = 2; sl = '0; sr = '0;
        while (steps < n) begin
            en = (int'($urandom_range(99)) >= stall_pct);
            if (stall_at == steps && stall_left > 0) begin en = 1'b0; stall_left--; end
            bus.en = en; bus.sinl = 1'($urandom); bus.sinr = 1'($urandom);
            bus.start = poke; bus.mode = 3'($urandom); bus.din = W'($urandom); bus.amt = AW'($urandom);
            if (en) begin sl[steps] = bus.sinl; sr[steps] = bus.sinr; end
            tick();
            cycles++;
            if (en) steps++;
            e = ref_multi(op, qs, '0, steps, sl, sr);
            check("run_q", {24'b0, bus.q}, {24'b0, e});
            check("run_sout_l", {31'b0, bus.sout_l}, {31'b0, e[W-1]});
            check("run_busy", {31'b0, bus.busy}, {31'b0, steps < n});
            if (cycles > 400) begin
                checks++; failures++;
                $display("FAIL run_timeout actual=%0d required=%0d", steps, n);
                break;
            end
        end
        mq = ref_multi(op, qs, '0, n, sl, sr);
        exp_q.push_back(mq);
        exp_b.push_back(cycles);
        bus.start = 1'b0; bus.en = 1'b0;
    endtask

    initial begin
        logic [2:0] m;
        bus.en = 0; bus.mode = 0; bus.din = 0; bus.sinl = 0; bus.sinr = 0;
        bus.start = 0; bus.amt = 0;
        mq = '0;
        #2;
        check("rst_q", {24'b0, bus.q}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        idle_step(3'b011, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("req_load_a5", {24'b0, bus.q}, 32'hA5);
        idle_step(3'b001, 8'h00, 1'b1, 1'b0, 1'b1);
        check("req_shl_4b", {24'b0, bus.q}, 32'h4B);
        idle_step(3'b010, 8'h00, 1'b1, 1'b0, 1'b1);
        check("req_shr_25", {24'b0, bus.q}, 32'h25);
        idle_step(3'b001, 8'h00, 1'b1, 1'b1, 1'b0);

        run_multi(3'b100, 8'h81, 4'd3, 0, -1, 1'b0);
        check("req_rotl_final", {24'b0, mq}, 32'h0C);
        run_multi(3'b110, 8'h90, 4'd2, 0, -1, 1'b0);
        check("req_asr_final", {24'b0, mq}, 32'hE4);
        run_multi(3'b101, 8'h5A, 4'd12, 0, -1, 1'b0);
        run_multi(3'b010, 8'h3C, 4'd4, 0, 2, 1'b1);
        run_multi(3'b001, 8'h77, 4'd0, 0, -1, 1'b0);
        start_single(3'b000, 8'h00);
        start_single(3'b111, 8'h00);

        // Reset dropped mid-run must clear outputs without a clock edge.
        start_single(3'b011, 8'hC3);
        bus.start = 1'b1; bus.mode = 3'b100; bus.amt = 4'd5; tick();
        bus.start = 1'b0; bus.en = 1'b1; tick(); tick();
        #1 reset = 1'b0;
        #1;
        check("mid_rst_q", {24'b0, bus.q}, 32'd0);
        check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'b0, bus.done}, 32'd0);
        mq = '0;
        tick();
        reset = 1'b1;
        run_multi(3'b100, 8'h81, 4'd3, 0, -1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(5))
                0, 1: idle_step(3'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                2: begin
                    m = 3'($urandom);
                    if (m == 3'b000 || m == 3'b011 || m == 3'b111) start_single(m, W'($urandom));
                    else idle_step(m, W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
                end
                default: begin
                    case ($urandom_range(4))
                        0: m = 3'b001;
                        1: m = 3'b010;
                        2: m = 3'b100;
                        3: m = 3'b101;
                        default: m = 3'b110;
                    endcase
                    run_multi(m, W'($urandom), AW'($urandom_range(15)), 25, -1, 1'($urandom));
                end
            endcase
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL pending_done actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/usr_param.md
USR_PARAM -- requirements
Module: usr_param

Interface
REQ-001 Parameter WIDTH, 8, register width in bits (≥2).
REQ-002 Parameter AW, $clog2(WIDTH+1), width of the amt port.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  step enable (single-step ops in IDLE; stall control in RUN).
REQ-006 mode  input  3  op: 000 hold, 001 shift left (sinl→bit0), 010 shift right (sinr→MSB), 011 parallel load, 100 rotate left, 101 rotate right, 110 arithmetic right, 111 clear.
REQ-007 din  input  WIDTH  parallel load data.
REQ-008 sinl  input  1  serial in for shift left (enters bit 0).
REQ-009 sinr  input  1  serial in for shift right (enters bit WIDTH-1).
REQ-010 start  input  1  request multi-step operation.
REQ-011 amt  input  AW  step count for multi-step op.
REQ-012 q  output  WIDTH  register contents.
REQ-013 sout_l  output  1  q[WIDTH-1], combinational from q.
REQ-014 sout_r  output  1  q[0], combinational from q.
REQ-015 busy  output  1  high while a multi-step op is running.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE and RUN; a registered down-counter cnt (AW bits) and latched op code SHALL be held.
REQ-018 IDLE, start=0, en=1: q SHALL take one step of mode at the edge; en=0: q SHALL hold.
REQ-019 Step definitions: shl q={q[W-2:0],sinl}; shr q={sinr,q[W-1:1]}; rotl q={q[W-2:0],q[W-1]}; rotr q={q[0],q[W-1:1]}; asr q={q[W-1],q[W-1:1]}; load q=din; clear q=0.
REQ-020 IDLE, start=1, mode in {001,010,100,101,110}: at that edge (E0) op and cnt=min(amt,WIDTH) SHALL be latched, q unchanged; amt>WIDTH SHALL clamp to WIDTH.
REQ-021 If latched cnt≠0, state SHALL go RUN and busy SHALL be 1 from E0 until the edge applying the last step.
REQ-022 If latched cnt=0, state SHALL remain IDLE, busy stays 0, done SHALL be 1 for the cycle after E0, q unchanged.
REQ-023 IDLE, start=1, mode in {000,011,111}: op SHALL execute once at E0 (en ignored), done SHALL be 1 for the following cycle, busy stays 0.
REQ-024 RUN, en=1: each edge SHALL apply one step of the latched op and decrement cnt; mode, din, amt, start SHALL be ignored.
REQ-025 RUN, en=0: q and cnt SHALL hold (stall); busy stays 1.
REQ-026 The edge applying the step with cnt=1 SHALL return to IDLE, clear busy, and set done for exactly the next cycle.
REQ-027 sinl/sinr SHALL be sampled fresh at every step edge during RUN.
REQ-028 start asserted while busy=1 SHALL be ignored and not queued.
REQ-029 done SHALL never be high for more than one consecutive cycle per accepted start; busy and done SHALL never be high together.

Reset
REQ-030 reset=0 SHALL immediately force q=0, cnt=0, busy=0, done=0, state IDLE, regardless of clk, including mid-RUN.
REQ-031 After reset release, first op SHALL be accepted at the first rising edge with reset=1.

Verification (WIDTH=8)
REQ-032 RUN rotl amt=5, drop reset after 2 steps -> q=0x00, busy=0, done=0 without a clock edge; next start accepted normally.
REQ-033 IDLE en=1 mode=011 din=0xA5 -> q=0xA5; then mode=001 sinl=1 -> q=0x4B; mode=010 sinr=0 -> q=0x25.
REQ-034 q=0x81, start mode=100 amt=3 -> q 0x03,0x06,0x0C over 3 edges after E0; busy high 3 cycles; done one cycle after.
REQ-035 q=0x90, start mode=110 amt=2 -> q 0xC8 then 0xE4; sout_l=1 throughout.
REQ-036 q=0x5A, start mode=101 amt=12 -> clamped to 8; busy 8 cycles; final q=0x5A; done pulse once.
REQ-037 RUN shr amt=4, en=0 for 2 cycles mid-run, start pulsed while busy -> busy lasts 6 cycles, q holds during stall, start ignored, single done.
